// File: rtl/alarm_sequencer.sv
// Alarm state sequencer: detects the alarm-time match edge and walks IDLE/RINGING/SNOOZE,
// producing the sound enable and the 1 Hz display blink phase.
module alarm_sequencer #(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZES      = 3,
    parameter int CNT_BITS         = 9,
    parameter int SNZ_BITS         = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sec_tick_i,
    input  logic [15:0]         time_hm_i,
    input  logic [15:0]         alarm_hm_i,
    input  logic                alarm_en_i,
    input  logic                setting_i,
    input  logic                stop_btn_i,
    input  logic                snooze_btn_i,
    output logic                sound_en_o,
    output logic                blink_o,
    output logic [1:0]          state_o,
    output logic [SNZ_BITS-1:0] snooze_count_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RINGING = 2'b01,
        SNOOZE  = 2'b10
    } state_e;

    localparam logic [CNT_BITS-1:0] RING_LAST  = CNT_BITS'(RING_TIMEOUT_SEC - 1);
    localparam logic [CNT_BITS-1:0] SNZ_LAST   = CNT_BITS'(SNOOZE_SEC - 1);
    localparam logic [SNZ_BITS-1:0] SNZ_MAX    = SNZ_BITS'(MAX_SNOOZES);

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] sec_cnt_q, sec_cnt_d;
    logic [SNZ_BITS-1:0] snz_q, snz_d;
    logic                blink_q, blink_d;
    logic                match_q;
    logic                match, match_rise;

    // match_q resets high so a match already present out of reset is not an edge
    assign match      = alarm_en_i & ~setting_i & (time_hm_i == alarm_hm_i);
    assign match_rise = match & ~match_q;

    always_comb begin
        state_d   = state_q;
        sec_cnt_d = sec_cnt_q;
        snz_d     = snz_q;
        blink_d   = 1'b0;
        if (!alarm_en_i) begin
            state_d   = IDLE;
            sec_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    sec_cnt_d = '0;
                    if (match_rise) begin
                        state_d = RINGING;
                        snz_d   = '0;
                    end
                end
                RINGING: begin
                    blink_d = blink_q;
                    if (stop_btn_i) begin
                        state_d   = IDLE;
                        sec_cnt_d = '0;
                        blink_d   = 1'b0;
                    end else if (snooze_btn_i && (snz_q < SNZ_MAX)) begin
                        state_d   = SNOOZE;
                        sec_cnt_d = '0;
                        snz_d     = snz_q + SNZ_BITS'(1);
                        blink_d   = 1'b0;
                    end else if (sec_tick_i) begin
                        // an exhausted snooze press falls through to the timer
                        if (sec_cnt_q == RING_LAST) begin
                            state_d   = IDLE;
                            sec_cnt_d = '0;
                            blink_d   = 1'b0;
                        end else begin
                            sec_cnt_d = sec_cnt_q + CNT_BITS'(1);
                            blink_d   = ~blink_q;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_btn_i) begin
                        state_d   = IDLE;
                        sec_cnt_d = '0;
                    end else if (sec_tick_i) begin
                        if (sec_cnt_q == SNZ_LAST) begin
                            state_d   = RINGING;
                            sec_cnt_d = '0;
                        end else begin
                            sec_cnt_d = sec_cnt_q + CNT_BITS'(1);
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    sec_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sec_cnt_q <= '0;
            snz_q     <= '0;
            blink_q   <= 1'b0;
            match_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            sec_cnt_q <= sec_cnt_d;
            snz_q     <= snz_d;
            blink_q   <= blink_d;
            match_q   <= match;
        end
    end

    assign sound_en_o     = (state_q == RINGING);
    assign blink_o        = blink_q;
    assign state_o        = state_q;
    assign snooze_count_o = snz_q;

endmodule
